// File: rtl/mux_pkg.sv
// Shared constants for the registered round-robin / fixed-priority mux.
// Holds the mode encodings and the default geometry used by rr_mux_reg.
package mux_pkg;

  // Arbitration mode encodings driven on rr_mux_reg.mode
  localparam logic MODE_RR    = 1'b0;  // rotating start point, fair
  localparam logic MODE_FIXED = 1'b1;  // lowest asserted index always wins

  // Default geometry
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_CH = 32;

  // Index that follows idx, wrapping from num_ch-1 back to 0.
  function automatic int next_index(input int idx, input int num_ch);
    if (idx >= num_ch - 1) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around find-first search.
// Starting at index ptr, walks req upward (ptr, ptr+1, ..., NUM_CH-1, 0, ...)
// and returns the first set bit as grant. any is 1 when at least one req bit
// is set; grant is 0 when any is 0. Pure combinational.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              any
);

  // Rotated priority search: the first requester at or after ptr wins.
  always_comb begin
    int idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N:1 arbitrating mux.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. Valid may rise or
// fall at any time without a transfer (requests are never latched here), and
// ready never depends on a transfer having already happened. On the input side
// ready is per channel (in_ready, one-hot or zero); on the output side the
// single stage is refilled in the same cycle it drains, so a continuous stream
// moves one word per cycle with no bubble.
//
// Arbitration: mode=MODE_RR searches from ptr with wrap-around, and ptr moves
// to grant+1 after every input handshake; mode=MODE_FIXED searches from 0 and
// leaves ptr untouched so round-robin resumes where it left off.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;        // round-robin search start
  logic [SEL_W-1:0] search_ptr; // start actually presented to the picker
  logic [SEL_W-1:0] grant;
  logic             any;
  logic             accept;     // output stage can take a word this cycle
  logic             in_fire;    // an input handshake happens this cycle
  logic [WIDTH-1:0] sel_data;

  // Stage is free when empty or being drained this very cycle.
  assign accept = !out_valid || out_ready;

  // Fixed priority is simply a search that always starts at channel 0.
  assign search_ptr = (mode == MODE_FIXED) ? '0 : ptr;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (search_ptr),
    .grant (grant),
    .any   (any)
  );

  // Reset gating keeps in_ready low while reset_n is held, even though the
  // empty stage would otherwise advertise accept.
  assign in_fire = reset_n && accept && any;

  // One-hot ready towards the granted channel only.
  always_comb begin
    in_ready = '0;
    if (in_fire) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Data of the granted channel.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Single output stage: load on handshake, empty when free and nothing asked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: advances past the winner only in MODE_RR handshakes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (accept && any && (mode == MODE_RR)) begin
      ptr <= SEL_W'(next_index(int'(grant), NUM_CH));
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg with NUM_CH=4, WIDTH=8.
// Channel k always presents data 8'hA0+k.
module tb_rr_mux_reg;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                    clock;
  logic                    reset_n;
  logic                    mode;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  int vectors;
  int miscompares;

  rr_mux_reg #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock: 10 time-unit period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mode      = 1'b0;
    in_valid  = 4'h0;
    out_ready = 1'b1;
    step();
    step();
    reset_n  = 1'b1;
    in_valid = 4'hF;
    step();
    // word from ch0 now held; assert reset away from any edge
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preload_valid: got %b expected 1", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async_data: got %h expected 00", out_data);
    end
    vectors++;
    if (out_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async_sel: got %0d expected 0", out_sel);
    end
    vectors++;
    if (in_ready !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_async_in_ready: got %b expected 0000", in_ready);
    end
    in_valid = 4'h0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    int exp_sel [5];
    logic [3:0] exp_rdy;
    exp_sel = '{0, 1, 2, 3, 0};
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_valid[%0d]: got %b expected 1", c, out_valid);
      end
      vectors++;
      if (out_sel !== SEL_W'(exp_sel[c])) begin
        miscompares++;
        $display("FAIL rr_sel[%0d]: got %0d expected %0d", c, out_sel, exp_sel[c]);
      end
      vectors++;
      if (out_data !== 8'hA0 + 8'(exp_sel[c])) begin
        miscompares++;
        $display("FAIL rr_data[%0d]: got %h expected %h", c, out_data, 8'hA0 + 8'(exp_sel[c]));
      end
      exp_rdy = 4'b0001 << ((exp_sel[c] + 1) % 4);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_in_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy);
      end
    end
    in_valid = 4'h0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_idle_valid: got %b expected 0", out_valid);
    end
    // ptr is now 1
  endtask

  task automatic test_fixed_priority();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL fixed_sel[%0d]: got sel %0d valid %b expected sel 1 valid 1", c, out_sel, out_valid);
      end
      vectors++;
      if (out_data !== 8'hA1) begin
        miscompares++;
        $display("FAIL fixed_data[%0d]: got %h expected a1", c, out_data);
      end
      vectors++;
      if (in_ready !== 4'b0010) begin
        miscompares++;
        $display("FAIL fixed_in_ready[%0d]: got %b expected 0010", c, in_ready);
      end
    end
    in_valid = 4'h0;
    step();
    // ptr still 1, stage empty
  endtask

  task automatic test_backpressure();
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA2) begin
      miscompares++;
      $display("FAIL bp_load: got v%b s%0d d%h expected v1 s2 da2", out_valid, out_sel, out_data);
    end
    in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (out_data !== 8'hA2 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v%b s%0d d%h expected v1 s2 da2", c, out_valid, out_sel, out_data);
      end
      vectors++;
      if (in_ready !== 4'h0) begin
        miscompares++;
        $display("FAIL bp_in_ready[%0d]: got %b expected 0000", c, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_release_in_ready: got %b expected 1000", in_ready);
    end
    step();
    vectors++;
    if (out_sel !== 2'd3 || out_data !== 8'hA3) begin
      miscompares++;
      $display("FAIL bp_next_grant: got s%0d d%h expected s3 da3", out_sel, out_data);
    end
    // ptr now 0
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hA1) begin
      miscompares++;
      $display("FAIL drain_last: got v%b s%0d d%h expected v1 s1 da1", out_valid, out_sel, out_data);
    end
    in_valid = 4'h0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_valid_fall: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 8'hA1 || out_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL drain_hold: got s%0d d%h expected s1 da1", out_sel, out_data);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'hA1) begin
      miscompares++;
      $display("FAIL drain_idle: got v%b d%h expected v0 da1", out_valid, out_data);
    end
    // ptr now 2
  endtask

  task automatic test_reset_mid_stream();
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_preload: got v%b s%0d expected v1 s1", out_valid, out_sel);
    end
    #2;
    reset_n = 1'b0;
    #3;
    reset_n   = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_discard: got %b expected 0", out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL mid_first_sel: got v%b s%0d d%h expected v1 s0 da0", out_valid, out_sel, out_data);
    end
    // ptr now 1
  endtask

  task automatic test_mode_switch();
    mode     = 1'b1;
    in_valid = 4'hF;
    step();
    vectors++;
    if (out_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL mode_fixed_sel: got %0d expected 0", out_sel);
    end
    mode = 1'b0;
    step();
    vectors++;
    if (out_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL mode_rr_resume_sel: got %0d expected 1", out_sel);
    end
    step();
    vectors++;
    if (out_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL mode_rr_next_sel: got %0d expected 2", out_sel);
    end
    in_valid = 4'h0;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_data     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_drain();
    test_reset_mid_stream();
    test_mode_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
RR_MUX_REG -- requirements
Module: rr_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per channel.
REQ-002 SHALL have parameter NUM_CH, default 32: number of input channels, 2..64.
REQ-003 SHALL have parameter SEL_W, default $clog2(NUM_CH): width of the channel index.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port mode, input, 1: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 SHALL have port in_data, input, NUM_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, NUM_CH: per-channel request.
REQ-009 SHALL have port in_ready, output, NUM_CH: per-channel accept, one-hot or zero.
REQ-010 SHALL have port out_data, output, WIDTH: registered selected data.
REQ-011 SHALL have port out_sel, output, SEL_W: index of the channel held in out_data.
REQ-012 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the word this cycle.

Function
REQ-014 SHALL define accept = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-015 SHALL compute grant among asserted in_valid bits combinationally; with mode=0, search starts at pointer ptr and wraps NUM_CH-1 -> 0; with mode=1, search starts at index 0.
REQ-016 SHALL assert in_ready[grant] only when accept=1 and at least one in_valid is set; all other in_ready bits SHALL be 0.
REQ-017 SHALL, on a cycle with accept=1 and a grant, load out_data=in_data[grant], out_sel=grant and out_valid=1 at the next edge (latency 1 cycle).
REQ-018 SHALL, on a cycle with accept=1 and no in_valid, clear out_valid at the next edge; out_data and out_sel SHALL hold.
REQ-019 SHALL, on a cycle with accept=0, hold out_data, out_sel and out_valid unchanged.
REQ-020 SHALL, in mode=0 on each input handshake, update ptr to grant+1, wrapping NUM_CH-1 -> 0; ptr SHALL hold in mode=1 and on non-handshake cycles.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held at 1 (pass-through; no bubble).
REQ-022 SHALL allow in_valid to drop without a handshake; no request is latched internally.
REQ-023 SHALL apply a mode change at the first arbitration after the change; ptr SHALL be retained across mode changes.
REQ-024 SHALL never drop or duplicate a word: each input handshake produces exactly one output handshake, in order.

Reset
REQ-025 SHALL, while reset_n=0, immediately force out_valid=0, out_data=0, out_sel=0 and ptr=0, independent of clock.
REQ-026 SHALL discard any held word when reset asserts mid-transfer; in_ready SHALL be 0 while reset_n=0.
REQ-027 SHALL resume arbitration on the first rising edge after reset_n deasserts.

Structure
REQ-028 SHALL take mode encodings (MODE_RR=0, MODE_FIXED=1) and the default WIDTH/NUM_CH constants from shared package mux_pkg.
REQ-029 SHALL implement the wrap-around find-first search as sub-module rr_pick (inputs req, ptr; outputs grant, any).
REQ-030 SHALL contain exactly one storage stage (out_data/out_sel/out_valid) plus the ptr register.

Verification (bench uses NUM_CH=4, WIDTH=8)
REQ-031 SHALL test reset: reset_n=0 with in_valid=4'hF asynchronously -> out_valid=0, out_data=0, out_sel=0, in_ready=0 before the next edge.
REQ-032 SHALL test round-robin fairness: mode=0, in_valid=4'hF constant, out_ready=1, data k=8'hA0+k -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-033 SHALL test fixed priority: mode=1, in_valid=4'b1010, out_ready=1 -> out_sel=1 every cycle; ch3 is never granted.
REQ-034 SHALL test backpressure: out_valid=1 holding ch2 (8'hA2), out_ready=0 for 3 cycles with in_valid=4'hF -> out_data stays 8'hA2 and in_ready=0; when out_ready=1, the next grant is ch3.
REQ-035 SHALL test drain: a single word with out_ready=1 and in_valid then 0 -> out_valid falls 1 cycle after the last handshake, and out_data holds its last value.
REQ-036 SHALL test reset mid-stream: reset_n pulsed low while out_valid=1 and ptr=2 -> after release, with in_valid=4'hF and mode=0, first out_sel=0.
